mem_word_arbiter: RTL
=====================

Name: mem_word_arbiter

Overview:
- Shares one byte-wide, 2^ADDR_W-entry memory between two 32-bit requesters: instruction fetch (read-only) and data (read/write).
- Serialises each word access into four byte accesses and assembles or scatters the word big-endian: the byte at addr holds bits 31:24, and addr+3 holds bits 7:0.
- Sits between the multicycle core's fetch/load-store logic and the unified byte memory array.
- Arbitrates round-robin on simultaneous requests.

Parameters:
- ADDR_W, 5, byte-address width; the memory depth is 2^ADDR_W bytes.

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held high until if_ack
- if_addr  in  ADDR_W  fetch byte address
- if_rdata  out  32  fetch word
- if_ack  out  1  one-cycle pulse; if_rdata valid from this cycle on
- d_req  in  1  data request; held high until d_ack
- d_we  in  1  1 = word write, 0 = word read
- d_addr  in  ADDR_W  data byte address
- d_wdata  in  32  data write word
- d_rdata  out  32  data read word
- d_ack  out  1  one-cycle pulse on completion of a data read or write
- mem_addr  out  ADDR_W  byte address to memory
- mem_we  out  1  byte write enable; memory writes on posedge clk
- mem_wdata  out  8  byte write data
- mem_rdata  in  8  byte read data; combinational from mem_addr in the same cycle
- busy  out  1  high in XFER and ACK states

Behaviour:
- Reset: state IDLE, byte count 0, last_grant = fetch.
  - Reset values: all outputs 0 (if_rdata, d_rdata, acks, mem_*, busy).
- States: IDLE, XFER, ACK.
- IDLE:
  - If only one request is high, grant it.
  - If both are high, grant the requester that is not last_grant. Since last_grant resets to fetch, the first tie after reset goes to data.
  - At the grant edge: latch owner, addr, we (forced 0 for fetch) and wdata; set count=0; go to XFER; update last_grant.
  - If no request is high, stay in IDLE.
- XFER (4 cycles, count 0..3):
  - mem_addr = latched addr + count, modulo 2^ADDR_W, so addresses wrap (e.g. addr 30 accesses 30, 31, 0, 1).
  - Write: mem_we=1 and mem_wdata = wdata byte count, where byte 0 is bits 31:24.
  - Read: mem_we=0, and at the posedge mem_rdata is captured into bits [31-8*count -: 8] of an internal assembly register.
  - After count==3, go to ACK.
- ACK (1 cycle):
  - Pulse the owner's ack.
  - On a read, the owner's rdata updates from the assembly register at the edge entering ACK, so rdata is valid in the ack cycle.
  - rdata holds until that port's next read completes; a write never changes d_rdata.
  - Next state is IDLE.
- Latency: an uncontended request seen in IDLE at cycle 0 gives XFER in cycles 1–4 and the ack in cycle 5. The minimum spacing between successive grants is 6 cycles.
- Outside XFER: mem_addr=0, mem_we=0, mem_wdata=0.
- Requester rules:
  - The requester must drop req in the cycle after its ack. A req still high in the IDLE that follows is treated as a new request.
  - A req dropped mid-transfer is ignored: the transfer completes and the ack is still pulsed.
  - Request inputs are sampled only in IDLE; changes during XFER have no effect on the current transfer.
- Unaligned addresses are legal and are handled by the wrap rule.
- Reset mid-transfer aborts immediately to IDLE with no ack. Bytes already written remain in memory.
- busy = (state != IDLE).

Test Plan:
1. Memory bytes 0..3 = 12 34 56 78; if_req with if_addr=0 -> in XFER, mem_addr steps 0,1,2,3; if_ack pulses in cycle 5; if_rdata=12345678; d_rdata stays 0.
2. d_req, d_we=1, d_addr=8, d_wdata=DEADBEEF -> mem bytes 8..11 = DE AD BE EF, mem_we high exactly 4 cycles, d_ack pulses once. Then a read of addr 8 -> d_rdata=DEADBEEF.
3. if_req and d_req both rise in the same cycle after reset -> data is served first. Fetch is granted in the IDLE right after d_ack. With both requests held continuously, grants alternate D, F, D, F.
4. d_addr=30 write of 11223344 -> bytes 30=11, 31=22, 0=33, 1=44; a fetch from 30 returns 11223344.
5. rst asserted in the 3rd XFER cycle of a write of AABBCCDD to addr 4 -> bytes 4,5 = AA,BB; bytes 6,7 unchanged; no d_ack; all outputs 0 in the next cycle; state IDLE.
6. if_req dropped after the grant -> the transfer completes, if_ack pulses in cycle 5, and no second grant occurs.

Source files
------------

// File: rtl/mem_word_arbiter_if.sv
// mem_word_arbiter_if: fetch, data and byte-memory signals shared by the word arbiter and its neighbours.
interface mem_word_arbiter_if #(parameter int ADDR_W = 5);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [31:0]       if_rdata;
   logic              if_ack;
   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [31:0]       d_wdata;
   logic [31:0]       d_rdata;
   logic              d_ack;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [7:0]        mem_wdata;
   logic [7:0]        mem_rdata;
   logic              busy;
   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      output if_rdata, if_ack, d_rdata, d_ack, mem_addr, mem_we, mem_wdata, busy
   );
   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
      input  if_rdata, if_ack, d_rdata, d_ack, mem_addr, mem_we, mem_wdata, busy
   );
endinterface

// File: rtl/mem_word_arbiter.sv
// mem_word_arbiter: round-robin fetch/data arbiter serialising 32-bit words into big-endian byte accesses.
module mem_word_arbiter #(parameter int ADDR_W = 5) (
   input logic clk,
   input logic rst,
   mem_word_arbiter_if.slave bus
);
   localparam logic [1:0] IDLE = 2'd0, XFER = 2'd1, ACK = 2'd2;
   logic [1:0]        state_q, state_d, cnt_q, cnt_d;
   logic              own_d_q, last_d_q, we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q, asm_q, if_rdata_q, d_rdata_q;
   logic              gnt, gnt_d, xfer, done;
   logic [4:0]        sh;
   always_comb begin
      gnt     = state_q == IDLE && (bus.if_req || bus.d_req);
      gnt_d   = bus.d_req && (!bus.if_req || !last_d_q);
      xfer    = state_q == XFER && !rst;
      done    = state_q == XFER && cnt_q == 2'd3;
      sh      = 5'd31 - {cnt_q, 3'b000};
      state_d = gnt ? XFER : done ? ACK : state_q == ACK ? IDLE : state_q;
      cnt_d   = state_q == XFER ? cnt_q + 2'd1 : 2'd0;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= 2'd0;
         own_d_q    <= 1'b0;
         last_d_q   <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         asm_q      <= '0;
         if_rdata_q <= '0;
         d_rdata_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (gnt) begin
            own_d_q  <= gnt_d;
            last_d_q <= gnt_d;
            addr_q   <= gnt_d ? bus.d_addr : bus.if_addr;
            we_q     <= gnt_d && bus.d_we;
            wdata_q  <= bus.d_wdata;
         end
         if (state_q == XFER && !we_q) asm_q[sh -: 8] <= bus.mem_rdata;
         // the last byte arrives on the same edge that enters ACK, so merge it directly
         if (done && !we_q && own_d_q) d_rdata_q <= {asm_q[31:8], bus.mem_rdata};
         if (done && !we_q && !own_d_q) if_rdata_q <= {asm_q[31:8], bus.mem_rdata};
      end
   end
   assign bus.mem_addr  = xfer ? addr_q + ADDR_W'(cnt_q) : '0;
   assign bus.mem_we    = xfer && we_q;
   assign bus.mem_wdata = xfer && we_q ? wdata_q[sh -: 8] : 8'd0;
   assign bus.if_ack    = state_q == ACK && !own_d_q;
   assign bus.d_ack     = state_q == ACK && own_d_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.d_rdata   = d_rdata_q;
   assign bus.busy      = state_q != IDLE;
endmodule
